// File: rtl/vz_pkg.sv
// Shared definitions for the VZ snapshot loader: FSM states, header constants
// and the FIFO entry layout.
package vz_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_DRAIN,
        S_PATCH_LO,
        S_PATCH_HI,
        S_DONE,
        S_ERROR
    } vz_state_e;

    localparam logic [31:0] VZ_MAGIC      = 32'h56_5A_46_30;
    localparam logic [7:0]  VZ_TYPE_BASIC = 8'hF0;
    localparam logic [7:0]  VZ_TYPE_BIN   = 8'hF1;
    localparam int unsigned VZ_HDR_LEN    = 24;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } vz_entry_t;
endpackage

// File: rtl/vz_loader_if.sv
// Download-stream, Z80 bus-handshake and RAM-write signals of the VZ loader.
interface vz_loader_if;
    logic        dn_go;
    logic [7:0]  dn_index;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        cpu_busak;
    logic        cpu_busrq;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output dn_go, dn_index, dn_addr, dn_data, dn_wr, cpu_busak,
        input  cpu_busrq, ram_addr, ram_wdata, ram_we, busy, done, error
    );

    modport slave (
        input  dn_go, dn_index, dn_addr, dn_data, dn_wr, cpu_busak,
        output cpu_busrq, ram_addr, ram_wdata, ram_we, busy, done, error
    );
endinterface

// File: rtl/vz_fifo.sv
// Small synchronous FIFO of {address, data} RAM writes; clr flushes it.
module vz_fifo
    import vz_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clr,
    input  logic      push,
    input  vz_entry_t din,
    input  logic      pop,
    output vz_entry_t dout,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);

    vz_entry_t     mem_q [DEPTH];
    logic [AW:0]   wr_q, rd_q;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/vz_loader.sv
// Parses a .vz download, streams its payload into RAM while the Z80 is held off
// the bus, then patches the BASIC end pointer or USR vector.
module vz_loader
    import vz_pkg::*;
#(
    parameter logic [7:0]  IDX           = 8'd1,
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [15:0] BASIC_END_PTR = 16'h78F9,
    parameter logic [15:0] USR_PTR       = 16'h788E
) (
    input  logic        CLK10MHZ,
    input  logic        RESET,
    vz_loader_if.slave  bus
);
    vz_state_e   state_q, state_d;
    logic        go_q;
    logic [23:0] magic_q, magic_d;
    logic [7:0]  type_q, type_d;
    logic [15:0] start_q, start_d;
    logic [15:0] end_q, end_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_wdata_q, ram_wdata_d;
    logic        ram_we_q, ram_we_d;
    logic        done_q;

    logic        fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
    vz_entry_t   fifo_din, fifo_dout;

    logic        idx_ok, go_rise, go_fall, wr_ok, in_hdr, is_basic;
    logic [15:0] off;

    assign idx_ok   = (bus.dn_index == IDX);
    assign go_rise  = bus.dn_go && !go_q && idx_ok;
    assign go_fall  = !bus.dn_go && go_q;
    assign wr_ok    = bus.dn_wr && idx_ok;
    assign in_hdr   = (bus.dn_addr < 16'(VZ_HDR_LEN));
    assign off      = bus.dn_addr - 16'(VZ_HDR_LEN);
    assign is_basic = (type_q == VZ_TYPE_BASIC);

    assign fifo_din = '{addr: start_q + off, data: bus.dn_data};

    vz_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLK10MHZ),
        .rst_n (RESET),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge CLK10MHZ) begin
        if (!RESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        magic_d     = magic_q;
        type_d      = type_q;
        start_d     = start_q;
        end_d       = end_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        fifo_clr    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (go_rise) begin
                    state_d  = S_HEADER;
                    magic_d  = '0;
                    fifo_clr = 1'b1;
                end
            end
            S_HEADER: begin
                if (go_fall) begin
                    state_d = S_ERROR;
                end else if (wr_ok && in_hdr) begin
                    case (bus.dn_addr[4:0])
                        5'd0: magic_d[23:16] = bus.dn_data;
                        5'd1: magic_d[15:8]  = bus.dn_data;
                        5'd2: magic_d[7:0]   = bus.dn_data;
                        5'd3: if ({magic_q, bus.dn_data} != VZ_MAGIC) state_d = S_ERROR;
                        5'd21: begin
                            type_d = bus.dn_data;
                            if (bus.dn_data != VZ_TYPE_BASIC && bus.dn_data != VZ_TYPE_BIN)
                                state_d = S_ERROR;
                        end
                        5'd22: start_d[7:0] = bus.dn_data;
                        5'd23: begin
                            start_d[15:8] = bus.dn_data;
                            end_d         = {bus.dn_data, start_q[7:0]};
                            state_d       = S_PAYLOAD;
                        end
                        default: ;
                    endcase
                end
            end
            S_PAYLOAD, S_DRAIN: begin
                fifo_pop = bus.cpu_busak && !fifo_empty;
                if (state_q == S_PAYLOAD && wr_ok && !in_hdr) begin
                    // A push into a full FIFO is only safe if a pop frees a slot this cycle.
                    if (fifo_full && !fifo_pop) begin
                        fifo_clr = 1'b1;
                        state_d  = S_ERROR;
                    end else begin
                        fifo_push = 1'b1;
                        end_d     = fifo_din.addr + 16'd1;
                    end
                end
                if (fifo_pop && !fifo_clr) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = fifo_dout.addr;
                    ram_wdata_d = fifo_dout.data;
                end
                if (state_d != S_ERROR) begin
                    if (state_q == S_PAYLOAD && go_fall)
                        state_d = S_DRAIN;
                    else if (state_q == S_DRAIN && fifo_empty && bus.cpu_busak)
                        state_d = S_PATCH_LO;
                end
            end
            S_PATCH_LO: begin
                ram_we_d    = 1'b1;
                ram_addr_d  = is_basic ? BASIC_END_PTR : USR_PTR;
                ram_wdata_d = is_basic ? end_q[7:0] : start_q[7:0];
                state_d     = S_PATCH_HI;
            end
            S_PATCH_HI: begin
                ram_we_d    = 1'b1;
                ram_addr_d  = (is_basic ? BASIC_END_PTR : USR_PTR) + 16'd1;
                ram_wdata_d = is_basic ? end_q[15:8] : start_q[15:8];
                state_d     = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK10MHZ) begin
        if (!RESET) begin
            go_q        <= 1'b0;
            magic_q     <= '0;
            type_q      <= '0;
            start_q     <= '0;
            end_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            go_q        <= bus.dn_go;
            magic_q     <= magic_d;
            type_q      <= type_d;
            start_q     <= start_d;
            end_q       <= end_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            done_q      <= (state_q == S_PATCH_HI);
        end
    end

    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.done      = done_q;
    assign bus.error     = (state_q == S_ERROR);
    assign bus.busy      = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign bus.cpu_busrq = state_q inside {S_PAYLOAD, S_DRAIN, S_PATCH_LO, S_PATCH_HI};
endmodule

// File: tb/tb_vz_loader.sv
// Directed and randomized VZ downloads checked against a list-of-writes model.
module tb_vz_loader;
    typedef logic [7:0] byte_q_t [$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    vz_loader_if bus();

    vz_loader #(
        .IDX(8'd1), .FIFO_DEPTH(4), .BASIC_END_PTR(16'h78F9), .USR_PTR(16'h788E)
    ) dut (
        .CLK10MHZ (clk),
        .RESET    (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // busak source: 0 = tied high, 1 = busrq delayed 3 cycles, 2 = manual level
    int       ak_mode = 0;
    logic     ak_man  = 1'b0;
    logic [2:0] rq_sh = '0;
    always @(posedge clk) rq_sh <= {rq_sh[1:0], bus.cpu_busrq};
    assign bus.cpu_busak = (ak_mode == 0) ? 1'b1 : (ak_mode == 1) ? rq_sh[2] : ak_man;

    logic [23:0] wq [$];
    int   done_cnt = 0;
    bit   busrq_seen = 0;
    always @(negedge clk) begin
        if (bus.ram_we)    wq.push_back({bus.ram_addr, bus.ram_wdata});
        if (bus.done)      done_cnt++;
        if (bus.cpu_busrq) busrq_seen = 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [7:0] d);
        bus.dn_addr = a;
        bus.dn_data = d;
        bus.dn_wr   = 1'b1;
        tick();
        bus.dn_wr   = 1'b0;
    endtask

    function automatic logic [7:0] hdr_byte(input int a, input logic [7:0] typ, input logic [15:0] st);
        logic [31:0] m = 32'h565A4630;
        if (a < 4)   return m[8*(3-a) +: 8];
        if (a == 21) return typ;
        if (a == 22) return st[7:0];
        if (a == 23) return st[15:8];
        return 8'(8'h41 + a);
    endfunction

    task automatic begin_dl();
        wq.delete();
        done_cnt   = 0;
        busrq_seen = 0;
        bus.dn_index = 8'd1;
        bus.dn_go    = 1'b1;
        tick();
    endtask

    task automatic load(input string tag, input logic [7:0] typ, input logic [15:0] st,
                        input byte_q_t pl, input int gap);
        logic [23:0] exp [$];
        logic [15:0] endv;
        int n;
        begin_dl();
        for (int a = 0; a < 24; a++) begin
            send(16'(a), hdr_byte(a, typ, st));
            if (a == 22) chk({tag, "_busrq_pre"}, {31'd0, bus.cpu_busrq}, 32'd0);
        end
        chk({tag, "_busrq_on"}, {31'd0, bus.cpu_busrq}, 32'd1);
        for (int i = 0; i < pl.size(); i++) begin
            repeat (gap) tick();
            send(16'(24 + i), pl[i]);
        end
        bus.dn_go = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_done_timeout"}, {31'd0, n < 400}, 32'd1);
        repeat (3) tick();
        chk({tag, "_done_once"}, done_cnt, 32'd1);
        chk({tag, "_busrq_off"}, {31'd0, bus.cpu_busrq}, 32'd0);
        chk({tag, "_error"}, {31'd0, bus.error}, 32'd0);
        for (int i = 0; i < pl.size(); i++) exp.push_back({16'(st + 16'(i)), pl[i]});
        endv = 16'(st + 16'(pl.size()));
        if (typ == 8'hF0) begin
            exp.push_back({16'h78F9, endv[7:0]});
            exp.push_back({16'h78FA, endv[15:8]});
        end else begin
            exp.push_back({16'h788E, st[7:0]});
            exp.push_back({16'h788F, st[15:8]});
        end
        chk({tag, "_nwrites"}, wq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < wq.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), {8'd0, wq[i]}, {8'd0, exp[i]});
    endtask

    initial begin
        byte_q_t pl;
        bus.dn_go = 1'b0; bus.dn_index = 8'd0; bus.dn_addr = '0; bus.dn_data = '0; bus.dn_wr = 1'b0;
        repeat (3) tick();
        chk("rst_busrq", {31'd0, bus.cpu_busrq}, 32'd0);
        chk("rst_outs", {bus.ram_we, bus.busy, bus.done, bus.error, 28'd0}, 32'd0);
        chk("rst_ram", {bus.ram_addr, bus.ram_wdata, 8'd0}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: BASIC image at 7AE9
        pl = '{8'hAA, 8'hBB, 8'hCC};
        load("t1", 8'hF0, 16'h7AE9, pl, 0);
        // 2: binary image at 8000
        pl = '{8'h12, 8'h34};
        load("t2", 8'hF1, 16'h8000, pl, 1);
        // zero-length BASIC payload
        pl = '{};
        load("zero", 8'hF0, 16'h1234, pl, 0);

        // 3: bad magic
        begin_dl();
        for (int a = 0; a < 3; a++) send(16'(a), hdr_byte(a, 8'hF0, 16'h7000));
        chk("magic_err_pre", {31'd0, bus.error}, 32'd0);
        send(16'd3, 8'h58);
        chk("magic_err", {31'd0, bus.error}, 32'd1);
        for (int a = 4; a < 30; a++) send(16'(a), hdr_byte(a, 8'hF0, 16'h7000));
        bus.dn_go = 1'b0;
        repeat (5) tick();
        chk("magic_nowr", wq.size(), 32'd0);
        chk("magic_norq", {31'd0, busrq_seen}, 32'd0);

        // bad type byte
        begin_dl();
        for (int a = 0; a < 22; a++) send(16'(a), hdr_byte(a, 8'h42, 16'h7000));
        chk("type_err", {31'd0, bus.error}, 32'd1);
        bus.dn_go = 1'b0;
        tick();

        // 4: busak low, 6 back-to-back bytes overflow the 4-deep FIFO
        ak_mode = 2; ak_man = 1'b0;
        begin_dl();
        for (int a = 0; a < 24; a++) send(16'(a), hdr_byte(a, 8'hF0, 16'h5000));
        chk("t1_clear_err", {31'd0, bus.error}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            send(16'(24 + i), 8'(i));
            if (i == 3) chk("ovf_pre", {31'd0, bus.error}, 32'd0);
            if (i == 4) chk("ovf_err", {31'd0, bus.error}, 32'd1);
        end
        chk("ovf_busrq", {31'd0, bus.cpu_busrq}, 32'd0);
        repeat (14) tick();
        ak_man = 1'b1;
        bus.dn_go = 1'b0;
        repeat (10) tick();
        chk("ovf_nowr", wq.size(), 32'd0);
        chk("ovf_sticky", {31'd0, bus.error}, 32'd1);

        // 5: busak trails busrq by 3 cycles, bytes every 8 cycles
        ak_mode = 1;
        pl = '{};
        for (int i = 0; i < 5; i++) pl.push_back(8'($urandom));
        load("t5", 8'hF0, 16'h9000, pl, 7);
        ak_mode = 0;

        // 6: reset in PAYLOAD, then a wrapping load
        begin_dl();
        for (int a = 0; a < 24; a++) send(16'(a), hdr_byte(a, 8'hF1, 16'h4000));
        send(16'd24, 8'h11);
        send(16'd25, 8'h22);
        rst_n = 1'b0;
        bus.dn_go = 1'b0;
        tick();
        chk("mid_rst_busrq", {31'd0, bus.cpu_busrq}, 32'd0);
        chk("mid_rst_outs", {bus.ram_we, bus.busy, bus.done, bus.error, 28'd0}, 32'd0);
        chk("mid_rst_ram", {bus.ram_addr, bus.ram_wdata, 8'd0}, 32'd0);
        rst_n = 1'b1;
        tick();
        pl = '{8'h01, 8'h02, 8'h03};
        load("wrap", 8'hF0, 16'hFFFE, pl, 0);

        // randomized loads
        for (int r = 0; r < 6; r++) begin
            pl = '{};
            for (int i = 0; i < $urandom_range(0, 8); i++) pl.push_back(8'($urandom));
            load($sformatf("rnd%0d", r), ($urandom_range(0, 1) != 0) ? 8'hF1 : 8'hF0,
                 16'($urandom), pl, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
